// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter_if
// Purpose  : Bundles the requester-side inputs and the display-side outputs of
//            seg_display_arbiter.
// Signals  : req[1:0]            level-sensitive display requests
//            digits0/digits1     24-bit active-low segment patterns per requester
//                                ([7:0] digit0, [15:8] digit1, [23:16] digit2)
//            dig_cnt0/dig_cnt1   digits in use, 1..3 (0 means 3)
//            grant[1:0]          one-hot current owner, 00 when idle
//            idle                no current owner
//            segs[7:0]           segment drive, active-low
//            bits[2:0]           digit enables, active-low
// Modports : master drives requests/patterns, slave is the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface seg_display_arbiter_if;
    logic [1:0]  req;
    logic [23:0] digits0;
    logic [23:0] digits1;
    logic [1:0]  dig_cnt0;
    logic [1:0]  dig_cnt1;
    logic [1:0]  grant;
    logic        idle;
    logic [7:0]  segs;
    logic [2:0]  bits;

    modport master (
        output req, digits0, digits1, dig_cnt0, dig_cnt1,
        input  grant, idle, segs, bits
    );

    modport slave (
        input  req, digits0, digits1, dig_cnt0, dig_cnt1,
        output grant, idle, segs, bits
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Shares one 3-digit multiplexed 7-segment display between two
//            requesters. Round-robin ownership with a minimum dwell time, one
//            blank slot on every ownership change, and the digit scan for the
//            current owner.
// Ports    : clk  system clock
//            rst  synchronous active-high reset
//            bus  seg_display_arbiter_if.slave (requests, patterns, grant,
//                 idle, segs, bits); all outputs registered
// Params   : SCAN_DIV  clk cycles per digit slot (also the blank slot length)
//            DWELL     minimum cycles an owner holds before a waiting
//                      requester may take over
// Options  : DISP_PRIO_EN  requester 0 preempts requester 1 at the next slot
//                          boundary and always wins idle ties
// Revision : 1.0  initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int SCAN_DIV = 32768,
    parameter int DWELL    = 50000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seg_display_arbiter_if.slave bus
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW_W   = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SCAN  = 2'd2
    } state_t;

    state_t             r_state,  w_state_n;
    logic               r_owner,  w_owner_n;       // owner index while granted
    logic               r_last,   w_last_n;        // most recently granted requester
    logic [1:0]         r_grant,  w_grant_n;
    logic               r_idle;
    logic [SLOT_W-1:0]  r_slot,   w_slot_n;
    logic [DW_W-1:0]    r_dwell,  w_dwell_n;
    logic [1:0]         r_digit,  w_digit_n;
    logic [1:0]         r_dcnt,   w_dcnt_n;        // digits in the current frame, 1..3
    logic [7:0]         r_segs,   w_segs_n;
    logic [2:0]         r_bits,   w_bits_n;

    logic               w_slot_end;
    logic               w_dwell_done;
    logic               w_own_req;
    logic               w_oth_req;
    logic               w_preempt;
    logic [23:0]        w_own_digits;
    logic [1:0]         w_cnt0;
    logic [1:0]         w_cnt1;
    logic [1:0]         w_own_cnt;
    logic               w_idle_winner;
    logic [1:0]         w_next_d;
    logic               w_take;
    logic               w_take_id;

    assign w_slot_end   = (r_slot == SLOT_W'(SCAN_DIV - 1));
    assign w_dwell_done = (r_dwell == DW_W'(DWELL));
    assign w_own_req    = bus.req[r_owner];
    assign w_oth_req    = bus.req[~r_owner];
    assign w_own_digits = r_owner ? bus.digits1 : bus.digits0;

    // A digit count of zero means all three digits.
    assign w_cnt0    = (bus.dig_cnt0 == 2'd0) ? 2'd3 : bus.dig_cnt0;
    assign w_cnt1    = (bus.dig_cnt1 == 2'd0) ? 2'd3 : bus.dig_cnt1;
    assign w_own_cnt = r_owner ? w_cnt1 : w_cnt0;

    // r_digit is always below r_dcnt, so this wraps at the frame end.
    assign w_next_d = (r_digit == r_dcnt - 2'd1) ? 2'd0 : r_digit + 2'd1;

`ifdef DISP_PRIO_EN
    // Requester 0 takes the display from requester 1 regardless of dwell.
    assign w_preempt     = r_owner;
    assign w_idle_winner = ~bus.req[0];
`else
    assign w_preempt     = 1'b0;
    // Sole requester wins; on a tie the one that did not own last wins.
    assign w_idle_winner = (bus.req == 2'b11) ? ~r_last : bus.req[1];
`endif

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_last_n  = r_last;
        w_grant_n = r_grant;
        w_digit_n = r_digit;
        w_dcnt_n  = r_dcnt;
        w_segs_n  = r_segs;
        w_bits_n  = r_bits;
        w_slot_n  = w_slot_end ? '0 : r_slot + SLOT_W'(1);
        w_dwell_n = w_dwell_done ? r_dwell : r_dwell + DW_W'(1);
        w_take    = 1'b0;
        w_take_id = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_segs_n  = 8'hFF;
                w_bits_n  = 3'b111;
                w_slot_n  = '0;
                w_dwell_n = '0;
                if (|bus.req) begin
                    w_take    = 1'b1;
                    w_take_id = w_idle_winner;
                end
            end

            S_BLANK: begin
                w_segs_n = 8'hFF;
                w_bits_n = 3'b111;
                if (w_slot_end) begin
                    w_state_n = S_SCAN;
                    w_digit_n = 2'd0;
                    w_dcnt_n  = w_own_cnt;
                    w_segs_n  = w_own_digits[7:0];
                    w_bits_n  = 3'b110;
                end
            end

            S_SCAN: begin
                if (w_slot_end) begin
                    if (!w_own_req) begin
                        if (w_oth_req) begin
                            w_take    = 1'b1;
                            w_take_id = ~r_owner;
                        end else begin
                            w_state_n = S_IDLE;
                            w_grant_n = 2'b00;
                            w_segs_n  = 8'hFF;
                            w_bits_n  = 3'b111;
                        end
                    end else if (w_oth_req && (w_dwell_done || w_preempt)) begin
                        w_take    = 1'b1;
                        w_take_id = ~r_owner;
                    end else begin
                        w_digit_n = w_next_d;
                        // Frame length only changes at the start of a frame.
                        if (w_next_d == 2'd0) begin
                            w_dcnt_n = w_own_cnt;
                        end
                        case (w_next_d)
                            2'd0:    begin w_segs_n = w_own_digits[7:0];   w_bits_n = 3'b110; end
                            2'd1:    begin w_segs_n = w_own_digits[15:8];  w_bits_n = 3'b101; end
                            default: begin w_segs_n = w_own_digits[23:16]; w_bits_n = 3'b011; end
                        endcase
                    end
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_grant_n = 2'b00;
                w_segs_n  = 8'hFF;
                w_bits_n  = 3'b111;
            end
        endcase

        // Any ownership change passes through one blank slot.
        if (w_take) begin
            w_state_n = S_BLANK;
            w_owner_n = w_take_id;
            w_last_n  = w_take_id;
            w_grant_n = w_take_id ? 2'b10 : 2'b01;
            w_dcnt_n  = w_take_id ? w_cnt1 : w_cnt0;
            w_digit_n = 2'd0;
            w_slot_n  = '0;
            w_dwell_n = '0;
            w_segs_n  = 8'hFF;
            w_bits_n  = 3'b111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
            r_idle  <= 1'b1;
            r_slot  <= '0;
            r_dwell <= '0;
            r_digit <= 2'd0;
            r_dcnt  <= 2'd3;
            r_segs  <= 8'hFF;
            r_bits  <= 3'b111;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_last  <= w_last_n;
            r_grant <= w_grant_n;
            r_idle  <= (w_grant_n == 2'b00);
            r_slot  <= w_slot_n;
            r_dwell <= w_dwell_n;
            r_digit <= w_digit_n;
            r_dcnt  <= w_dcnt_n;
            r_segs  <= w_segs_n;
            r_bits  <= w_bits_n;
        end
    end

    assign bus.grant = r_grant;
    assign bus.idle  = r_idle;
    assign bus.segs  = r_segs;
    assign bus.bits  = r_bits;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Purpose  : Directed scoreboard bench for seg_display_arbiter with
//            SCAN_DIV=4, DWELL=20. The stimulus process queues the hand-derived
//            expected outputs for every clock; a monitor pops and compares
//            them one time unit after each rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_display_arbiter;

    localparam int SCAN_DIV = 4;
    localparam int DWELL    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .SCAN_DIV (SCAN_DIV),
        .DWELL    (DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] g;
        logic [7:0] s;
        logic [2:0] b;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Queue n cycles of expected outputs, one per rising edge.
    task automatic cyc(input logic [1:0] g, input logic [7:0] s,
                       input logic [2:0] b, input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.g   = g;
            e.s   = s;
            e.b   = b;
            e.tag = tag;
            q.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic dark(input logic [1:0] g, input string tag, input int n);
        cyc(g, 8'hFF, 3'b111, tag, n);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if ({bus.grant, bus.idle, bus.segs, bus.bits} ===
                    {e.g, (e.g == 2'b00), e.s, e.b}) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @%0t: got grant=%b idle=%b segs=%h bits=%b, want grant=%b idle=%b segs=%h bits=%b",
                             e.tag, $time, bus.grant, bus.idle, bus.segs, bus.bits,
                             e.g, (e.g == 2'b00), e.s, e.b);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.req      = 2'b00;
        bus.digits0  = 24'h9F2503;
        bus.digits1  = 24'h99B0A4;
        bus.dig_cnt0 = 2'd3;
        bus.dig_cnt1 = 2'd2;
        rst          = 1'b1;

        // Reset and idle
        dark(2'b00, "reset", 2);
        rst = 1'b0;
        dark(2'b00, "idle_noreq", 3);

        // Requester 0 alone, three digits, then mid-slot release
        bus.req = 2'b01;
        dark(2'b01, "r0_blank", 4);
        cyc(2'b01, 8'h03, 3'b110, "r0_d0", 4);
        cyc(2'b01, 8'h25, 3'b101, "r0_d1", 4);
        cyc(2'b01, 8'h9F, 3'b011, "r0_d2", 4);
        cyc(2'b01, 8'h03, 3'b110, "r0_d0_wrap", 2);
        bus.req = 2'b00;
        cyc(2'b01, 8'h03, 3'b110, "r0_slot_finish", 2);
        dark(2'b00, "release_idle", 2);

        // Tie from idle after requester 0 owned last
        bus.req = 2'b11;
`ifdef DISP_PRIO_EN
        dark(2'b01, "tie_blank", 4);
        cyc(2'b01, 8'h03, 3'b110, "tie_d0", 4);
`else
        dark(2'b10, "tie_blank", 4);
        cyc(2'b10, 8'hA4, 3'b110, "tie_d0", 4);
`endif
        rst = 1'b1;
        dark(2'b00, "mid_reset", 1);

        // Both request from reset: requester 0 first, dwell switch to 1
        rst     = 1'b0;
        bus.req = 2'b11;
        dark(2'b01, "both_blank0", 4);
        cyc(2'b01, 8'h03, 3'b110, "both_d0", 4);
        cyc(2'b01, 8'h25, 3'b101, "both_d1", 4);
        cyc(2'b01, 8'h9F, 3'b011, "both_d2", 4);
        cyc(2'b01, 8'h03, 3'b110, "both_d0b", 4);
        cyc(2'b01, 8'h25, 3'b101, "both_d1b_no_switch", 4);
        dark(2'b10, "dwell_switch", 1);
        bus.req = 2'b10;
        dark(2'b10, "switch_blank", 3);

        // Requester 1 with two digits, then dig_cnt1=0 relatched at frame start
        cyc(2'b10, 8'hA4, 3'b110, "r1_d0", 4);
        cyc(2'b10, 8'hB0, 3'b101, "r1_d1", 4);
        cyc(2'b10, 8'hA4, 3'b110, "r1_d0_wrap", 4);
        cyc(2'b10, 8'hB0, 3'b101, "r1_d1b", 2);
        bus.dig_cnt1 = 2'd0;
        cyc(2'b10, 8'hB0, 3'b101, "r1_d1b_tail", 2);
        cyc(2'b10, 8'hA4, 3'b110, "r1_3d_d0", 4);
        cyc(2'b10, 8'hB0, 3'b101, "r1_3d_d1", 4);
        cyc(2'b10, 8'h99, 3'b011, "r1_3d_d2", 4);
        cyc(2'b10, 8'hA4, 3'b110, "r1_3d_wrap", 4);

        // Requester 1 owns, requester 0 arrives early in its tenure
        rst = 1'b1;
        dark(2'b00, "reset2", 1);
        rst     = 1'b0;
        bus.req = 2'b10;
        dark(2'b10, "p_blank", 4);
        cyc(2'b10, 8'hA4, 3'b110, "p_d0", 2);
        bus.req = 2'b11;
        cyc(2'b10, 8'hA4, 3'b110, "p_d0_tail", 2);
`ifdef DISP_PRIO_EN
        dark(2'b01, "prio_blank", 4);
        cyc(2'b01, 8'h03, 3'b110, "prio_r0_d0", 4);
`else
        cyc(2'b10, 8'hB0, 3'b101, "rr_d1", 4);
        cyc(2'b10, 8'h99, 3'b011, "rr_d2", 4);
        cyc(2'b10, 8'hA4, 3'b110, "rr_d0", 4);
        cyc(2'b10, 8'hB0, 3'b101, "rr_d1_no_switch", 4);
        dark(2'b01, "rr_blank", 4);
        cyc(2'b01, 8'h03, 3'b110, "rr_r0_d0", 4);
`endif

        @(posedge clk);
        #2;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the board's single 3-digit multiplexed 7-segment display between two requesters, e.g. the rotary-encoder readout and a status/debug source. Grants ownership round-robin with a minimum dwell time and runs the digit-scan sequencer for the current owner. Inserts one blank slot on every ownership change so the old owner's digits never ghost into the new owner's frame. Sits between the display-pattern producers and the `segs`/`bits` pins.

Parameters:
SCAN_DIV, 32768, clk cycles per digit slot; also the length of the blank slot.
DWELL, 50000000, minimum clk cycles an owner holds the display before a waiting requester can take it.

Ports:
clk  input  1  system clock; sole clock domain.
rst  input  1  synchronous, active-high reset.
req  input  2  req[i]=1: requester i wants the display; level-sensitive.
digits0  input  24  requester 0 segment patterns, active-low; [7:0] digit0, [15:8] digit1, [23:16] digit2.
digits1  input  24  requester 1 segment patterns, same layout.
dig_cnt0  input  2  requester 0 digits in use, 1..3; 0 is treated as 3.
dig_cnt1  input  2  requester 1 digits in use, same encoding.
grant  output  2  one-hot current owner; 00 when idle.
idle  output  1  1 when no owner.
segs  output  8  segment drive, active-low.
bits  output  3  digit enables, active-low; at most one bit low.

Behaviour:
Reset values:
- segs=8'hFF, bits=3'b111, grant=2'b00, idle=1, state=IDLE.
- last_owner=1, so requester 0 wins the first tie.
- Slot and dwell counters cleared.
- Asserting rst mid-operation returns to these values on the next edge.

Counters:
- Slot counter: width clog2(SCAN_DIV); counts 0..SCAN_DIV-1, then wraps. The wrap cycle is the "slot boundary".
- Dwell counter: width clog2(DWELL+1); cleared at grant, increments each cycle, saturates at DWELL.

State IDLE:
- Outputs segs=FF, bits=111.
- If any req bit is set: the next edge registers grant and enters BLANK.
- Winner is the only requester, or on a tie the one not equal to last_owner.
- On entering BLANK: latch owner dig_cnt, update last_owner, clear both counters.

State BLANK:
- One slot of segs=FF, bits=111.
- At the slot boundary enter SCAN with digit index 0.

State SCAN:
- Digit index d steps 0..n-1, then wraps to 0; one slot per digit; n is the latched dig_cnt.
- d=0: bits=110, segs=owner [7:0].
- d=1: bits=101, segs=owner [15:8].
- d=2: bits=011, segs=owner [23:16].
- The owner's digits word is latched at slot start; mid-slot changes appear from the next slot.
- dig_cnt is re-latched only at d=0 slot start.

Arbitration (evaluated only at SCAN slot boundaries, never mid-slot):
- (a) Owner req=0: release. If the other req=1, grant it and enter BLANK; otherwise grant=00 and go to IDLE.
- (b) Owner req=1, other req=1, dwell==DWELL: switch to the other requester, enter BLANK.
- (c) Otherwise continue scanning.
- In BLANK, req changes are ignored until SCAN is reached.

Outputs and timing:
- grant changes on the same edge as the state change; idle = (grant==00).
- All outputs are registered.
- Latency from req rise in IDLE to grant: 1 cycle.
- Latency from grant to first lit digit: SCAN_DIV cycles.
- Simultaneous release by the owner and a new request from the other requester: handled by (a); the other is granted with no IDLE cycle.

Optional Feature:
DISP_PRIO_EN
- Defined: requester 0 has priority. While requester 1 owns, req[0]=1 forces a switch at the next slot boundary regardless of dwell. Requester 0 always wins IDLE ties. Requester 1 can only preempt requester 0 via dwell rule (b).
- Undefined: pure round-robin as specified above.

Test Plan:
1. SCAN_DIV=4, DWELL=20; rst high 2 cycles, req=00 -> segs=FF, bits=111, grant=00, idle=1 throughout.
2. req=01, digits0=24'h9F2503, dig_cnt0=3 -> grant=01 one cycle after req; 4 blank cycles; then repeating (bits=110, segs=03) x4, (101, 25) x4, (011, 9F) x4.
3. req=11 from reset -> grant=01 first. Switch to grant=10 at the first slot boundary with dwell≥20, then 4 blank cycles before requester 1's digit0. Never switch mid-slot.
4. Requester 1 owns with dig_cnt1=2 -> bits alternates 110/101 every 4 cycles; 011 never appears. dig_cnt1=0 -> all three digits scanned.
5. Owner drops req mid-slot, other req=0 -> current slot completes; next cycle grant=00, idle=1, segs=FF, bits=111.
6. DISP_PRIO_EN defined: requester 1 owns, dwell=3, req[0] rises -> grant=01 at the next slot boundary, then a blank slot. Without the macro, the switch waits until dwell≥20.
